// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY music sequencer: script opcodes,
// POKEY register addresses, sequencer state encoding.
package pokey_pkg;

    localparam logic [3:0] OP_END   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_WAIT  = 4'h2;
    localparam logic [3:0] OP_JUMP  = 4'h3;

    localparam logic [3:0] AUDF0  = 4'h0;
    localparam logic [3:0] AUDC0  = 4'h1;
    localparam logic [3:0] AUDF1  = 4'h2;
    localparam logic [3:0] AUDC1  = 4'h3;
    localparam logic [3:0] AUDF2  = 4'h4;
    localparam logic [3:0] AUDC2  = 4'h5;
    localparam logic [3:0] AUDF3  = 4'h6;
    localparam logic [3:0] AUDC3  = 4'h7;
    localparam logic [3:0] AUDCTL = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_HOLD,
        S_WAITF,
        S_MUTE
    } seq_state_e;

    // Channel control register silenced by the n-th mute write.
    function automatic logic [3:0] mute_addr(input logic [1:0] idx);
        logic [3:0] a;
        a = AUDC0;
        unique case (idx)
            2'd0: a = AUDC0;
            2'd1: a = AUDC1;
            2'd2: a = AUDC2;
            2'd3: a = AUDC3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/pokey_bus_mux.sv
// CPU-priority POKEY write mux with registered outputs.
// Ports: cpu_* / seq_* write requests in, seq_grant to FSM, pk_* to POKEY.
module pokey_bus_mux (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_din,
    input  logic       seq_req,
    input  logic [3:0] seq_addr,
    input  logic [7:0] seq_din,
    output logic       seq_grant,
    output logic       pk_we,
    output logic [3:0] pk_addr,
    output logic [7:0] pk_din
);

    assign seq_grant = seq_req & ~cpu_we;

    // Address/data hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pk_we   <= 1'b0;
            pk_addr <= 4'h0;
            pk_din  <= 8'h00;
        end else if (cpu_we) begin
            pk_we   <= 1'b1;
            pk_addr <= cpu_addr;
            pk_din  <= cpu_din;
        end else if (seq_req) begin
            pk_we   <= 1'b1;
            pk_addr <= seq_addr;
            pk_din  <= seq_din;
        end else begin
            pk_we   <= 1'b0;
        end
    end

endmodule

// File: rtl/pokey_music_sequencer.sv
// Plays a music/SFX script from ROM into POKEY, sharing the bus with the CPU.
// Ports: frame_tick/start/stop control, rom_addr/rom_data script ROM,
// cpu_* CPU writes, pk_* POKEY writes, busy status.
module pokey_music_sequencer
    import pokey_pkg::*;
#(
    parameter int ROM_AW = 10,
    parameter int WAIT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              stop,
    input  logic [ROM_AW-1:0] start_addr,
    output logic              busy,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              pk_we,
    output logic [3:0]        pk_addr,
    output logic [7:0]        pk_din
);

    seq_state_e        state, state_n;
    logic [ROM_AW-1:0] pc, pc_n;
    logic [WAIT_W-1:0] cnt, cnt_n;
    logic [1:0]        mute_idx, mute_idx_n;
    logic [3:0]        hold_addr, hold_addr_n;
    logic [7:0]        hold_din, hold_din_n;
    logic              seq_req, seq_grant;
    logic [3:0]        seq_addr;
    logic [7:0]        seq_din;
    logic [3:0]        op;
    logic              abort, restart;

    assign op       = rom_data[15:12];
    assign busy     = (state != S_IDLE);
    assign rom_addr = pc;

    // stop beats start; neither has any effect once muting.
    assign abort   = stop && state != S_IDLE && state != S_MUTE;
    assign restart = start && !stop && state != S_MUTE;

    // Write request kept apart from next-state logic so the grant
    // feedback from the mux does not form a combinational loop.
    always_comb begin
        seq_req  = 1'b0;
        seq_addr = hold_addr;
        seq_din  = hold_din;
        if (!abort && !restart) begin
            unique case (state)
                S_DECODE: begin
                    if (op == OP_WRITE) begin
                        seq_req  = 1'b1;
                        seq_addr = rom_data[11:8];
                        seq_din  = rom_data[7:0];
                    end
                end
                S_HOLD: seq_req = 1'b1;
                S_MUTE: begin
                    seq_req  = 1'b1;
                    seq_addr = mute_addr(mute_idx);
                    seq_din  = 8'h00;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        cnt_n       = cnt;
        mute_idx_n  = mute_idx;
        hold_addr_n = hold_addr;
        hold_din_n  = hold_din;
        if (abort) begin
            state_n    = S_MUTE;
            mute_idx_n = 2'd0;
        end else if (restart) begin
            pc_n    = start_addr;
            state_n = S_FETCH;
        end else begin
            unique case (state)
                S_IDLE:  ;
                S_FETCH: state_n = S_DECODE;
                S_DECODE: begin
                    unique case (op)
                        OP_END: begin
                            state_n    = S_MUTE;
                            mute_idx_n = 2'd0;
                        end
                        OP_WRITE: begin
                            if (seq_grant) begin
                                pc_n    = pc + ROM_AW'(1);
                                state_n = S_FETCH;
                            end else begin
                                hold_addr_n = rom_data[11:8];
                                hold_din_n  = rom_data[7:0];
                                state_n     = S_HOLD;
                            end
                        end
                        OP_WAIT: begin
                            if (rom_data[WAIT_W-1:0] == '0) begin
                                pc_n    = pc + ROM_AW'(1);
                                state_n = S_FETCH;
                            end else begin
                                cnt_n   = rom_data[WAIT_W-1:0];
                                state_n = S_WAITF;
                            end
                        end
                        OP_JUMP: begin
                            pc_n    = rom_data[ROM_AW-1:0];
                            state_n = S_FETCH;
                        end
                        default: begin
                            pc_n    = pc + ROM_AW'(1);
                            state_n = S_FETCH;
                        end
                    endcase
                end
                S_HOLD: begin
                    if (seq_grant) begin
                        pc_n    = pc + ROM_AW'(1);
                        state_n = S_FETCH;
                    end
                end
                S_WAITF: begin
                    if (frame_tick) begin
                        if (cnt == WAIT_W'(1)) begin
                            pc_n    = pc + ROM_AW'(1);
                            state_n = S_FETCH;
                        end else begin
                            cnt_n = cnt - WAIT_W'(1);
                        end
                    end
                end
                S_MUTE: begin
                    if (seq_grant) begin
                        if (mute_idx == 2'd3) state_n = S_IDLE;
                        mute_idx_n = mute_idx + 2'd1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            cnt       <= '0;
            mute_idx  <= 2'd0;
            hold_addr <= 4'h0;
            hold_din  <= 8'h00;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            cnt       <= cnt_n;
            mute_idx  <= mute_idx_n;
            hold_addr <= hold_addr_n;
            hold_din  <= hold_din_n;
        end
    end

    pokey_bus_mux u_mux (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .seq_req   (seq_req),
        .seq_addr  (seq_addr),
        .seq_din   (seq_din),
        .seq_grant (seq_grant),
        .pk_we     (pk_we),
        .pk_addr   (pk_addr),
        .pk_din    (pk_din)
    );

endmodule
